// File: rtl/stream_fanout_fork.sv
// Single-entry fork: holds one token and broadcasts it to every selected, enabled consumer.
// Optional STREAM_FANOUT_FORK_TOKEN_COUNT_EN adds a saturating completed-token counter (tok_count).
module stream_fanout_fork #(
   parameter int unsigned NUM_OUT    = 9,
   parameter int unsigned DATA_WIDTH = 17
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clk_en,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_OUT-1:0]            out_en,
   input  logic [NUM_OUT-1:0]            out_sel,
   output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]            out_valid,
   input  logic [NUM_OUT-1:0]            out_ready
`ifdef STREAM_FANOUT_FORK_TOKEN_COUNT_EN
   ,output logic [15:0]                  tok_count
`endif
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]            state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [NUM_OUT-1:0]    sel_q;
   logic [NUM_OUT-1:0]    taken_q;
   logic [NUM_OUT-1:0]    eff;
   logic [NUM_OUT-1:0]    done;
   logic                  full;
   logic                  all_done;
   logic                  accept;
   logic                  complete;

   // Outputs are masked by rst_n so a token held when reset asserts is never offered.
   always_comb begin
      full      = (state_q == HOLD);
      eff       = out_en & sel_q;
      done      = ~eff | taken_q | out_ready;
      all_done  = &done;
      out_valid = rst_n ? ({NUM_OUT{full}} & eff & ~taken_q) : '0;
      in_ready  = ~rst_n | ~full | all_done;
      accept    = in_valid & in_ready & clk_en;
      complete  = full & all_done & clk_en;
   end

   assign out_data = {NUM_OUT{data_q}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         sel_q   <= '0;
         taken_q <= '0;
      end else if (clk_en) begin
         if (flush) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            taken_q <= '0;
         end else if (accept) begin
            state_q <= HOLD;
            data_q  <= in_data;
            sel_q   <= out_sel;
            taken_q <= '0;
         end else if (complete) begin
            state_q <= EMPTY;
            taken_q <= '0;
         end else begin
            taken_q <= taken_q | (out_valid & out_ready);
         end
      end
   end

`ifdef STREAM_FANOUT_FORK_TOKEN_COUNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clk_en) begin
         if (flush) begin
            cnt_q <= '0;
         end else if (complete && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign tok_count = cnt_q;
`endif

endmodule

// File: tb/tb_stream_fanout_fork.sv
// Randomized and directed bench for stream_fanout_fork against a token/remaining-consumer model.
module tb_stream_fanout_fork;
   localparam int N = 9;
   localparam int W = 17;

   logic           clk = 1'b0;
   logic           rst_n, clk_en, flush, in_valid, in_ready;
   logic [W-1:0]   in_data;
   logic [N-1:0]   out_en, out_sel, out_valid, out_ready;
   logic [N*W-1:0] out_data;
`ifdef STREAM_FANOUT_FORK_TOKEN_COUNT_EN
   logic [15:0]    tok_count;
`endif

   int checks = 0;
   int errors = 0;

   // model: held token and the set of consumers still owed a copy
   bit           m_full = 1'b0;
   logic [W-1:0] m_data = '0;
   logic [N-1:0] m_rem  = '0;
   int           m_cnt  = 0;

   stream_fanout_fork #(.NUM_OUT(N), .DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_en(out_en), .out_sel(out_sel), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
`ifdef STREAM_FANOUT_FORK_TOKEN_COUNT_EN
      , .tok_count(tok_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called 1 time unit after a rising edge with inputs already driven.
   task automatic step();
      logic [N-1:0] ev;
      logic         er;
      logic         alldone;
      logic         acc;
      alldone = 1'b0;
      #4;
      if (!rst_n) begin
         ev = '0;
         er = 1'b1;
      end else begin
         ev      = m_full ? (m_rem & out_en) : '0;
         alldone = ((m_rem & out_en & ~out_ready) == '0);
         er      = !m_full || alldone;
      end
      check("out_valid", 32'(out_valid), 32'(ev));
      check("in_ready", 32'(in_ready), 32'(er));
      for (int i = 0; i < N; i++)
         if (ev[i]) check("out_data", 32'(out_data[i*W +: W]), 32'(m_data));
`ifdef STREAM_FANOUT_FORK_TOKEN_COUNT_EN
      check("tok_count", 32'(tok_count), 32'(m_cnt));
`endif
      if (!rst_n) begin
         m_full = 1'b0; m_rem = '0; m_cnt = 0;
      end else if (clk_en) begin
         if (flush) begin
            m_full = 1'b0; m_rem = '0; m_cnt = 0;
         end else begin
            acc = in_valid && er;
            if (m_full && alldone && m_cnt < 65535) m_cnt++;
            if (acc) begin
               m_full = 1'b1; m_data = in_data; m_rem = out_sel;
            end else if (m_full && alldone) begin
               m_full = 1'b0; m_rem = '0;
            end else if (m_full) begin
               m_rem = m_rem & ~(out_en & out_ready);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      out_en = '1; out_sel = '0; out_ready = '0;
      @(posedge clk);
      #1;
      step(); step();
      rst_n = 1'b1;
      step();

      // broadcast, 8 back-to-back tokens
      out_en = '1; out_sel = '1; out_ready = '1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data = W'(17'h00A5 + k);
         step();
      end
      in_valid = 1'b0;
      step();

      // staggered ready
      out_sel = 9'h003; out_ready = 9'h001; in_valid = 1'b1; in_data = 17'h1234;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      out_ready = 9'h003;
      step();
      step();

      // empty mask
      out_en = 9'h1FF; out_sel = 9'h000; in_valid = 1'b1; in_data = 17'h0BEEF;
      step();
      in_valid = 1'b0;
      step(); step();

      // flush mid-HOLD, then flush racing an accept
      out_sel = 9'h007; out_ready = 9'h003; in_valid = 1'b1; in_data = 17'h15555;
      step();
      in_valid = 1'b0;
      step();
      out_ready = '0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      out_ready = '1; in_valid = 1'b1; in_data = 17'h0AAAA;
      step();
      in_valid = 1'b0;
      step();
      flush = 1'b1; in_valid = 1'b1; in_data = 17'h00777;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();

      // reset with clk_en low during HOLD
      out_ready = '0; in_valid = 1'b1; in_data = 17'h01111;
      step();
      in_valid = 1'b0;
      step();
      clk_en = 1'b0; rst_n = 1'b0;
      step();
      clk_en = 1'b1; rst_n = 1'b1;
      step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         clk_en   = ($urandom_range(0, 9) != 0);
         flush    = clk_en && ($urandom_range(0, 49) == 0);
         rst_n    = ($urandom_range(0, 299) != 0);
         in_valid = $urandom_range(0, 3) != 0;
         in_data  = W'($urandom);
         out_sel  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         if ($urandom_range(0, 19) == 0) out_en = N'($urandom) | N'($urandom);
         out_ready = N'($urandom) | N'($urandom);
         step();
      end
      rst_n = 1'b1; clk_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
      step();

`ifdef STREAM_FANOUT_FORK_TOKEN_COUNT_EN
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; out_en = '1; out_sel = '1; out_ready = '1; in_valid = 1'b1;
      for (int c = 0; c < 65545; c++) begin
         in_data = W'(c);
         step();
      end
      in_valid = 1'b0;
      step(); step();
      check("tok_count_sat", 32'(tok_count), 32'h0000FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_fanout_fork.md
STREAM_FANOUT_FORK -- requirements
Module: stream_fanout_fork

Interface
REQ-001 Parameter NUM_OUT, default 9: number of downstream consumers.
REQ-002 Parameter DATA_WIDTH, default 17: token width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 clk_en  input  1  when 0, all state holds and no handshake completes.
REQ-006 flush  input  1  synchronous clear of all datapath state.
REQ-007 in_data  input  DATA_WIDTH  upstream token.
REQ-008 in_valid  input  1  upstream token valid.
REQ-009 in_ready  output  1  block accepts the token this cycle.
REQ-010 out_en  input  NUM_OUT  static per-consumer enable.
REQ-011 out_sel  input  NUM_OUT  per-token destination select; sampled with in_data.
REQ-012 out_data  output  NUM_OUT*DATA_WIDTH  broadcast copy of the held token, one slice per consumer.
REQ-013 out_valid  output  NUM_OUT  per-consumer valid.
REQ-014 out_ready  input  NUM_OUT  per-consumer ready.

Function
REQ-015 Storage SHALL be one holding register (data, latched sel mask, full flag) plus a NUM_OUT-bit taken vector.
REQ-016 States SHALL be EMPTY (full=0) and HOLD (full=1).
REQ-017 Accept SHALL occur when in_valid & in_ready & clk_en.
REQ-018 out_valid[i] SHALL equal full & out_en[i] & sel_q[i] & ~taken[i].
REQ-019 out_data slices SHALL all equal the held data. Values are don't-care while full=0.
REQ-020 done[i] SHALL equal ~out_en[i] | ~sel_q[i] | taken[i] | out_ready[i]. all_done SHALL be the AND of done over all i.
REQ-021 in_ready SHALL equal ~full | all_done, so a new token is accepted in the same cycle the held token completes.
REQ-022 Per consumer, taken[i] SHALL set on out_valid[i] & out_ready[i] and hold until the token completes.
REQ-023 Completion SHALL occur when full & all_done & clk_en. On completion, taken SHALL clear. The block SHALL move to EMPTY, or stay in HOLD with the new token when an accept happens in the same cycle.
REQ-024 Latency SHALL be 1 cycle: a token accepted in cycle N drives out_valid in cycle N+1. Back-to-back tokens SHALL sustain 1 token per cycle when all selected consumers are ready.
REQ-025 Each selected, enabled consumer SHALL see each token exactly once, in arrival order, independent of the other consumers' ready timing.
REQ-026 A token whose effective mask (out_en & sel_q) is all zero SHALL complete in the first cycle it is held, with no out_valid asserted.
REQ-027 A change to out_en while in HOLD SHALL take effect combinationally. Clearing out_en[i] releases consumer i from the current token.
REQ-028 flush SHALL clear full and taken and force in_ready=1 in the following cycle. flush SHALL override a simultaneous accept, which is discarded.

Reset
REQ-029 With rst_n=0 at a clk edge, the block SHALL clear full, taken and sel_q. clk_en SHALL NOT gate this reset.
REQ-030 During reset and in the cycle after it, out_valid SHALL be all 0 and in_ready SHALL be 1.
REQ-031 A held token present at reset SHALL be discarded. Partially delivered copies are not replayed.

Configuration
REQ-032 Macro STREAM_FANOUT_FORK_TOKEN_COUNT_EN, when defined, SHALL add output port tok_count (16 bits): a count of completed tokens.
REQ-033 tok_count SHALL increment on each completion and saturate at 16'hFFFF.
REQ-034 tok_count SHALL clear on reset and on flush.
REQ-035 Without STREAM_FANOUT_FORK_TOKEN_COUNT_EN, the tok_count port and its logic SHALL be absent. All other behaviour SHALL be identical with and without the macro.

Verification
REQ-036 Broadcast: NUM_OUT=9, out_en=all 1, sel=9'h1FF, all ready, in_data=17'h00A5 -> every out_valid=1 with data 17'h00A5 one cycle after accept; sustained 1 token/cycle for 8 tokens.
REQ-037 Staggered ready: sel=9'h003, out_ready[0]=1, out_ready[1] low for 3 cycles -> consumer 0 gets exactly one copy; in_ready=0 for 3 cycles; completion in the cycle out_ready[1] rises.
REQ-038 Empty mask: out_en=9'h1FF, sel=9'h000 -> no out_valid; token completes one cycle after accept; in_ready stays 1.
REQ-039 Flush mid-HOLD: flush with 2 of 3 selected copies taken -> next cycle full=0, in_ready=1; the next token is delivered to all 3 consumers.
REQ-040 Reset mid-operation: rst_n=0 with clk_en=0 during HOLD -> out_valid=0 next cycle; tok_count=0 when STREAM_FANOUT_FORK_TOKEN_COUNT_EN is defined.
REQ-041 Saturation (macro defined): drive 65540 completions -> tok_count=16'hFFFF and held there.
